seq_stage_sequencer: RTL and testbench
======================================

// Module: seq_stage_sequencer
// PURPOSE
//  Top-level stage sequencer for the Y86-64 SEQ core. Steps one instruction at a time through
//  FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PC_UPDATE using a start/done handshake per stage.
//  The handshake is required because Execute takes several cycles through the 64-bit ALU.
//  Skips MEMORY and WRITEBACK for icodes that do not use them, and gates the condition-code write.
//  Owns the processor status (AOK/HLT/ADR/INS), a per-stage watchdog, and the cycle/retire counters.
// PARAMETERS
//  CNT_W    32   width of the cycle_count and instr_count counters (both saturate)
//  TIMEOUT  64   max cycles to wait for a stage done before faulting; must be >= 2
// PORTS
//  clk             in   1      core clock, all logic on posedge
//  reset           in   1      synchronous, active-high
//  run             in   1      level; when high in IDLE, start sequencing
//  icode           in   4      instruction code from Fetch, valid while fetch_done=1
//  fetch_done      in   1      Fetch stage complete (1-cycle pulse)
//  imem_error      in   1      instruction-address invalid, qualified by fetch_done
//  instr_invalid   in   1      bad icode/ifun, qualified by fetch_done
//  decode_done     in   1      Decode complete
//  execute_done    in   1      Execute complete (Value_E and cond valid)
//  memory_done     in   1      Memory complete
//  dmem_error      in   1      data-address invalid, qualified by memory_done
//  writeback_done  in   1      Writeback complete
//  fetch_start, decode_start, execute_start, memory_start, writeback_start  out 1 each
//                               1-cycle pulse on entry to the matching state
//  pc_update_en    out  1      1-cycle pulse in PC_UPDATE; the PC register loads new PC
//  set_cc          out  1      1-cycle pulse: load SF/OF/ZF from Execute
//  stat            out  2      STAT_AOK/HLT/ADR/INS
//  stage           out  3      current state encoding (debug)
//  busy            out  1      state is not IDLE and not HALT
//  halted          out  1      state is HALT
//  timeout_err     out  1      sticky: watchdog fired
//  cycle_count     out  CNT_W  cycles spent with busy=1
//  instr_count     out  CNT_W  instructions retired (PC_UPDATE visits)
// BEHAVIOUR
//  - Reset, sync, active-high: state=IDLE, all pulses 0, stat=AOK, timeout_err=0, counters=0.
//    Reset is honoured in any state, including mid-stage; a pending done is discarded.
//  - FSM: IDLE -run-> FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> PC_UPDATE.
//    PC_UPDATE returns to FETCH if run=1, else IDLE. HALT is absorbing until reset.
//  - Each stage state asserts its start pulse in its first cycle only.
//    It waits for the matching done; it advances on the cycle after done is sampled.
//    A done arriving in the same cycle as start is accepted.
//  - FETCH exit, priority order:
//    1. imem_error -> stat=ADR, HALT.
//    2. instr_invalid -> stat=INS, HALT.
//    3. icode==0 -> stat=HLT, HALT.
//    4. Otherwise latch icode and go to DECODE.
//  - After EXECUTE: go to MEMORY if icode in {4,5,8,9,A,B}, else WRITEBACK-check.
//  - WRITEBACK is entered if icode in {2,3,5,6,8,9,A,B}, else PC_UPDATE directly.
//    nop (1) and jXX (7) go EXECUTE->PC_UPDATE.
//  - set_cc pulses in the cycle execute_done is sampled, only when the latched icode==6.
//  - MEMORY exit: if dmem_error, then stat=ADR, go to HALT, and issue no writeback and no pc_update_en.
//  - Watchdog: counter clears on each state entry and increments while waiting.
//    On reaching TIMEOUT-1 without done: timeout_err=1, stat=ADR, HALT.
//  - Counting: cycle_count increments each cycle busy=1. instr_count increments in PC_UPDATE.
//    Both saturate at all-ones.
//  - run deasserted mid-instruction: the current instruction completes, then IDLE. run is ignored in HALT.
//  - Stray done inputs for a stage not currently active are ignored.
// STRUCTURE
//  - Shared package y86_pkg: icode constants (I_HALT..I_POPQ), STAT_AOK=0/HLT=1/ADR=2/INS=3.
//    The state enum is also shared with the debug/trace monitor.
//  - The icode-class decode (uses_mem, uses_wb, sets_cc) is pure combinational, local functions.
//  - One sub-module: stage_watchdog (load/clear, count, expire at TIMEOUT-1), reused per stage.
// TESTING
//  - irmovq (icode 3), all dones 1 cycle after start:
//    -> sequence F,D,E,W,PC; no memory_start; instr_count=1; stat=AOK.
//  - addq (icode 6):
//    -> set_cc pulses exactly once, coincident with execute_done.
//    - Same check for jXX (icode 7): set_cc=0 and no writeback_start.
//  - halt (icode 0) with fetch_done:
//    -> stat=HLT, halted=1, no decode_start.
//    - A subsequent run=1 has no effect; instr_count unchanged.
//  - fetch_done with imem_error=1 and instr_invalid=1 together -> stat=ADR (priority).
//    - mrmovq with dmem_error -> stat=ADR, no writeback_start, no pc_update_en.
//  - TIMEOUT=8, withhold execute_done:
//    -> timeout_err=1 and HALT exactly 8 cycles after execute_start.
//  - reset mid-EXECUTE, then execute_done arrives after reset:
//    -> IDLE, counters 0, done ignored, no set_cc.
//    - Next run restarts at FETCH.

Source files
------------

// File: rtl/seq_stage_sequencer_pkg.sv
// Shared definitions for the Y86-64 SEQ stage sequencer: icodes, status codes, state encoding.
package seq_stage_sequencer_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Encoding is visible on the debug 'stage' output and used by the trace monitor.
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StPcUpdate  = 3'd6,
    StHalt      = 3'd7
  } seq_state_e;

  // States that wait on a stage done and are covered by the watchdog.
  function automatic logic is_wait_state(input seq_state_e st);
    return (st == StFetch) || (st == StDecode) || (st == StExecute) ||
           (st == StMemory) || (st == StWriteback);
  endfunction

endpackage

// File: rtl/seq_stage_sequencer_if.sv
// Stage start/done handshake bundle between the sequencer and the datapath stages.
interface seq_stage_sequencer_if;

  logic       run;
  logic [3:0] icode;
  logic       fetch_done;
  logic       imem_error;
  logic       instr_invalid;
  logic       decode_done;
  logic       execute_done;
  logic       memory_done;
  logic       dmem_error;
  logic       writeback_done;

  logic       fetch_start;
  logic       decode_start;
  logic       execute_start;
  logic       memory_start;
  logic       writeback_start;
  logic       pc_update_en;
  logic       set_cc;

  // Sequencer side.
  modport master (
    input  run, icode, fetch_done, imem_error, instr_invalid, decode_done,
           execute_done, memory_done, dmem_error, writeback_done,
    output fetch_start, decode_start, execute_start, memory_start, writeback_start,
           pc_update_en, set_cc
  );

  // Datapath / stage side.
  modport slave (
    output run, icode, fetch_done, imem_error, instr_invalid, decode_done,
           execute_done, memory_done, dmem_error, writeback_done,
    input  fetch_start, decode_start, execute_start, memory_start, writeback_start,
           pc_update_en, set_cc
  );

endinterface

// File: rtl/seq_stage_sequencer_watchdog.sv
// Per-stage watchdog: cleared on every state entry, counts while a stage waits,
// expires when the count reaches TIMEOUT-1 while still waiting.
module seq_stage_sequencer_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // Wait-cycle counter; holds at Last so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != Last)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = en && (cnt_q == Last);

endmodule

// File: rtl/seq_stage_sequencer.sv
// Y86-64 SEQ stage sequencer: walks one instruction through the stages with a
// start/done handshake, tracks processor status, watchdog faults and counters.
module seq_stage_sequencer
  import seq_stage_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_stage_sequencer_if.master bus,
  output logic [1:0]           stat,
  output logic [2:0]           stage,
  output logic                 busy,
  output logic                 halted,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     instr_count
);

  function automatic logic uses_mem(input logic [3:0] ic);
    case (ic)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  function automatic logic uses_wb(input logic [3:0] ic);
    case (ic)
      I_RRMOVQ, I_IRMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
      default:                                                             return 1'b0;
    endcase
  endfunction

  function automatic logic sets_cc(input logic [3:0] ic);
    return ic == I_OPQ;
  endfunction

  seq_state_e       state_q, state_d;
  logic             entry_q;
  logic [3:0]       icode_q, icode_d;
  logic [1:0]       stat_q, stat_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cyc_q, ins_q;
  logic             wd_en, wd_expired;

  assign wd_en = is_wait_state(state_q);

  seq_stage_sequencer_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // State, latched icode, status and sticky timeout; entry_q marks a state's first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      entry_q <= 1'b0;
      icode_q <= I_HALT;
      stat_q  <= STAT_AOK;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      icode_q <= icode_d;
      stat_q  <= stat_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state, status update and set_cc; a done always wins over a same-cycle expiry.
  always_comb begin
    state_d    = state_q;
    icode_d    = icode_q;
    stat_d     = stat_q;
    tmo_d      = tmo_q;
    bus.set_cc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        if (bus.fetch_done) begin
          if (bus.imem_error) begin
            stat_d  = STAT_ADR;
            state_d = StHalt;
          end else if (bus.instr_invalid) begin
            stat_d  = STAT_INS;
            state_d = StHalt;
          end else if (bus.icode == I_HALT) begin
            stat_d  = STAT_HLT;
            state_d = StHalt;
          end else begin
            icode_d = bus.icode;
            state_d = StDecode;
          end
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          stat_d  = STAT_ADR;
          state_d = StHalt;
        end
      end
      StDecode: begin
        if (bus.decode_done) begin
          state_d = StExecute;
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          stat_d  = STAT_ADR;
          state_d = StHalt;
        end
      end
      StExecute: begin
        if (bus.execute_done) begin
          bus.set_cc = sets_cc(icode_q);
          if (uses_mem(icode_q))     state_d = StMemory;
          else if (uses_wb(icode_q)) state_d = StWriteback;
          else                       state_d = StPcUpdate;
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          stat_d  = STAT_ADR;
          state_d = StHalt;
        end
      end
      StMemory: begin
        if (bus.memory_done) begin
          if (bus.dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = StHalt;
          end else if (uses_wb(icode_q)) begin
            state_d = StWriteback;
          end else begin
            state_d = StPcUpdate;
          end
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          stat_d  = STAT_ADR;
          state_d = StHalt;
        end
      end
      StWriteback: begin
        if (bus.writeback_done) begin
          state_d = StPcUpdate;
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          stat_d  = STAT_ADR;
          state_d = StHalt;
        end
      end
      StPcUpdate: begin
        state_d = bus.run ? StFetch : StIdle;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Saturating busy-cycle and retired-instruction counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (busy && (cyc_q != '1))                    cyc_q <= cyc_q + CNT_W'(1);
      if ((state_q == StPcUpdate) && (ins_q != '1)) ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign bus.fetch_start     = entry_q && (state_q == StFetch);
  assign bus.decode_start    = entry_q && (state_q == StDecode);
  assign bus.execute_start   = entry_q && (state_q == StExecute);
  assign bus.memory_start    = entry_q && (state_q == StMemory);
  assign bus.writeback_start = entry_q && (state_q == StWriteback);
  assign bus.pc_update_en    = (state_q == StPcUpdate);

  assign stat        = stat_q;
  assign stage       = state_q;
  assign busy        = (state_q != StIdle) && (state_q != StHalt);
  assign halted      = (state_q == StHalt);
  assign timeout_err = tmo_q;
  assign cycle_count = cyc_q;
  assign instr_count = ins_q;

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// Directed bench for the SEQ stage sequencer; a stage responder answers each
// start with its done one cycle later, a monitor records the start order.
module tb_seq_stage_sequencer;

  logic        clk;
  logic        reset;
  logic [1:0]  stat;
  logic [2:0]  stage;
  logic        busy;
  logic        halted;
  logic        timeout_err;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  seq_stage_sequencer_if bus ();

  seq_stage_sequencer #(
    .CNT_W   (32),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .stat        (stat),
    .stage       (stage),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: start order as hex digits F=1 D=2 E=3 M=4 W=5 PC=6.
  int unsigned trace;
  int          n_start [1:6];
  int          n_cc, n_cc_bad;
  int          tb_cyc, exec_cyc, halt_cyc;

  task automatic clr_mon();
    trace = 0;
    for (int i = 1; i <= 6; i++) n_start[i] = 0;
    n_cc     = 0;
    n_cc_bad = 0;
    exec_cyc = -1;
    halt_cyc = -1;
  endtask

  // Sample on the falling edge; inputs only change 2 time units after a rising edge.
  always @(negedge clk) begin
    tb_cyc++;
    if (bus.fetch_start)     begin n_start[1]++; trace = (trace << 4) | 1; end
    if (bus.decode_start)    begin n_start[2]++; trace = (trace << 4) | 2; end
    if (bus.execute_start)   begin n_start[3]++; trace = (trace << 4) | 3; exec_cyc = tb_cyc; end
    if (bus.memory_start)    begin n_start[4]++; trace = (trace << 4) | 4; end
    if (bus.writeback_start) begin n_start[5]++; trace = (trace << 4) | 5; end
    if (bus.pc_update_en)    begin n_start[6]++; trace = (trace << 4) | 6; end
    if (bus.set_cc) begin
      n_cc++;
      if (!bus.execute_done) n_cc_bad++;
    end
    if (halted && (halt_cyc < 0)) halt_cyc = tb_cyc;
  end

  task automatic clr_inputs();
    bus.fetch_done     = 1'b0;
    bus.imem_error     = 1'b0;
    bus.instr_invalid  = 1'b0;
    bus.icode          = 4'h0;
    bus.decode_done    = 1'b0;
    bus.execute_done   = 1'b0;
    bus.memory_done    = 1'b0;
    bus.dmem_error     = 1'b0;
    bus.writeback_done = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.run = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    clr_mon();
  endtask

  // One-cycle run pulse from IDLE: the instruction starts, then the sequencer returns to IDLE.
  task automatic start_run();
    bus.run = 1'b1;
    @(posedge clk);
    #2;
    bus.run = 1'b0;
  endtask

  // Answer each stage start with its done one cycle later until PC update, HALT,
  // or (stop_exec) the execute start.
  task automatic drive_instr(input logic [3:0] ic, input bit ierr, input bit inv,
                             input bit derr, input bit hold_e, input bit stop_exec);
    int pend;
    bit fin;
    pend = 0;
    fin  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.fetch_start)     pend = 1;
      if (bus.decode_start)    pend = 2;
      if (bus.execute_start)   pend = 3;
      if (bus.memory_start)    pend = 4;
      if (bus.writeback_start) pend = 5;
      if (bus.pc_update_en || halted) fin = 1'b1;
      if (stop_exec && bus.execute_start) fin = 1'b1;
      @(posedge clk);
      #2;
      clr_inputs();
      case (pend)
        1: begin
          bus.fetch_done    = 1'b1;
          bus.icode         = ic;
          bus.imem_error    = ierr;
          bus.instr_invalid = inv;
        end
        2: bus.decode_done = 1'b1;
        3: bus.execute_done = !hold_e;
        4: begin
          bus.memory_done = 1'b1;
          bus.dmem_error  = derr;
        end
        5: bus.writeback_done = 1'b1;
        default: ;
      endcase
      pend = 0;
      if (fin) break;
    end
    check_eq("drive_finished", 64'(fin), 64'd1);
  endtask

  initial begin
    tb_cyc = 0;
    do_reset();

    // Reset state
    check_eq("rst_stage", 64'(stage), 64'd0);
    check_eq("rst_stat", 64'(stat), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_halted", 64'(halted), 64'd0);
    check_eq("rst_tmo", 64'(timeout_err), 64'd0);
    check_eq("rst_cyc", 64'(cycle_count), 64'd0);
    check_eq("rst_ins", 64'(instr_count), 64'd0);

    // irmovq: F D E W PC, two cycles per handshaked stage plus one PC cycle
    clr_mon();
    start_run();
    drive_instr(4'h3, 0, 0, 0, 0, 0);
    check_eq("irmovq_trace", 64'(trace), 64'h12356);
    check_eq("irmovq_no_mem", 64'(n_start[4]), 64'd0);
    check_eq("irmovq_ins", 64'(instr_count), 64'd1);
    check_eq("irmovq_stat", 64'(stat), 64'd0);
    check_eq("irmovq_idle", 64'(stage), 64'd0);
    check_eq("irmovq_cyc", 64'(cycle_count), 64'd9);

    // addq: set_cc once, coincident with execute_done
    clr_mon();
    start_run();
    drive_instr(4'h6, 0, 0, 0, 0, 0);
    check_eq("addq_trace", 64'(trace), 64'h12356);
    check_eq("addq_cc", 64'(n_cc), 64'd1);
    check_eq("addq_cc_align", 64'(n_cc_bad), 64'd0);
    check_eq("addq_ins", 64'(instr_count), 64'd2);

    // jXX: no memory, no writeback, no set_cc
    clr_mon();
    start_run();
    drive_instr(4'h7, 0, 0, 0, 0, 0);
    check_eq("jxx_trace", 64'(trace), 64'h1236);
    check_eq("jxx_cc", 64'(n_cc), 64'd0);
    check_eq("jxx_no_wb", 64'(n_start[5]), 64'd0);
    check_eq("jxx_ins", 64'(instr_count), 64'd3);

    // halt: HLT status, no decode; later run is ignored
    clr_mon();
    start_run();
    drive_instr(4'h0, 0, 0, 0, 0, 0);
    check_eq("halt_trace", 64'(trace), 64'h1);
    check_eq("halt_stat", 64'(stat), 64'd1);
    check_eq("halt_halted", 64'(halted), 64'd1);
    check_eq("halt_busy", 64'(busy), 64'd0);
    bus.run = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    bus.run = 1'b0;
    check_eq("halt_run_stage", 64'(stage), 64'd7);
    check_eq("halt_run_fetch", 64'(n_start[1]), 64'd1);
    check_eq("halt_run_ins", 64'(instr_count), 64'd3);

    // imem_error beats instr_invalid
    do_reset();
    start_run();
    drive_instr(4'h3, 1, 1, 0, 0, 0);
    check_eq("prio_stat", 64'(stat), 64'd2);
    check_eq("prio_halted", 64'(halted), 64'd1);
    check_eq("prio_no_dec", 64'(n_start[2]), 64'd0);

    // instr_invalid alone
    do_reset();
    start_run();
    drive_instr(4'h3, 0, 1, 0, 0, 0);
    check_eq("ins_stat", 64'(stat), 64'd3);
    check_eq("ins_halted", 64'(halted), 64'd1);

    // mrmovq with dmem_error
    do_reset();
    start_run();
    drive_instr(4'h5, 0, 0, 1, 0, 0);
    check_eq("dmem_trace", 64'(trace), 64'h1234);
    check_eq("dmem_stat", 64'(stat), 64'd2);
    check_eq("dmem_no_wb", 64'(n_start[5]), 64'd0);
    check_eq("dmem_no_pc", 64'(n_start[6]), 64'd0);
    check_eq("dmem_ins", 64'(instr_count), 64'd0);

    // Watchdog: execute_done withheld, HALT 8 cycles after execute_start
    do_reset();
    start_run();
    drive_instr(4'h6, 0, 0, 0, 1, 0);
    check_eq("tmo_delay", 64'(halt_cyc - exec_cyc), 64'd8);
    check_eq("tmo_err", 64'(timeout_err), 64'd1);
    check_eq("tmo_stat", 64'(stat), 64'd2);
    check_eq("tmo_cc", 64'(n_cc), 64'd0);

    // Reset mid-EXECUTE; a late execute_done must be ignored
    do_reset();
    start_run();
    drive_instr(4'h6, 0, 0, 0, 1, 1);
    check_eq("mid_in_exec", 64'(stage), 64'd3);
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.execute_done = 1'b1;
    @(posedge clk);
    #2;
    bus.execute_done = 1'b0;
    @(negedge clk);
    check_eq("mid_stage", 64'(stage), 64'd0);
    check_eq("mid_cyc", 64'(cycle_count), 64'd0);
    check_eq("mid_ins", 64'(instr_count), 64'd0);
    check_eq("mid_stat", 64'(stat), 64'd0);
    check_eq("mid_cc", 64'(n_cc), 64'd0);
    @(posedge clk);
    #2;
    clr_mon();
    start_run();
    drive_instr(4'h1, 0, 0, 0, 0, 0);
    check_eq("restart_trace", 64'(trace), 64'h1236);
    check_eq("restart_ins", 64'(instr_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
